// File: rtl/pipe_mon_pkg.sv
// Shared types and constants for the pipeline run monitor.
package pipe_mon_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } mon_state_t;

    localparam logic [1:0] FAIL_NONE    = 2'd0;
    localparam logic [1:0] FAIL_TIMEOUT = 2'd1;
    localparam logic [1:0] FAIL_HANG    = 2'd2;

    localparam int TRACE_REG_W   = 5;
    localparam int TRACE_CYCLE_W = 32;

    // Layout of one trace entry at the default 32-bit counter width.
    typedef struct packed {
        logic [TRACE_REG_W-1:0]   dst_reg;
        logic [TRACE_CYCLE_W-1:0] cycle;
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with a registered show-ahead head and a sticky overflow flag.
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] head,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             overflow_q, overflow_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop     = pop && (count_q != '0);
        // A full FIFO still accepts a push when the head leaves on the same edge.
        do_push    = push && ((count_q != (AW+1)'(DEPTH)) || do_pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (push && !do_push);
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
        valid_d = (count_d != '0);
        if (count_d == '0) begin
            head_d = '0;
        end else if (do_push && (wr_ptr_q == rd_ptr_d)) begin
            head_d = push_data;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            head_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            head_q     <= head_d;
            overflow_q <= overflow_d;
        end
    end

    assign valid    = valid_q;
    assign head     = head_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/pipe_monitor.sv
// Pipeline run monitor: saturating perf counters, pass/timeout/hang verdict and
// an optional writeback trace FIFO built when PIPE_MON_TRACE_EN is defined.
module pipe_monitor
    import pipe_mon_pkg::*;
#(
    parameter logic [31:0] END_PC      = 32'h58,
    parameter int          TIMEOUT     = 4096,
    parameter int          STALL_LIMIT = 16,
    parameter int          CNT_W       = 32,
    parameter int          TRACE_DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc,
    input  logic             reg_write_w,
    input  logic [4:0]       write_reg_w,
    input  logic             stall_f,
    input  logic             stall_d,
    input  logic             flush_e,
    input  logic             trace_pop,
    output logic             trace_valid,
    output logic [4:0]       trace_reg,
    output logic [CNT_W-1:0] trace_cycle,
    output logic             trace_overflow,
    output logic             done,
    output logic             pass,
    output logic [1:0]       fail_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int SC_W = $clog2(STALL_LIMIT) + 1;

    mon_state_t       state_q, state_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [1:0]       fail_code_q, fail_code_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] retire_q, retire_d;
    logic [CNT_W-1:0] stall_q, stall_d_cnt;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic [SC_W-1:0]  stall_run_q, stall_run_d;
    logic             retire_ev;
    logic             trace_push;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    always_comb begin
        state_d     = state_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_code_d = fail_code_q;
        cycle_d     = cycle_q;
        retire_d    = retire_q;
        stall_d_cnt = stall_q;
        flush_d     = flush_q;
        stall_run_d = stall_run_q;
        retire_ev   = reg_write_w && (write_reg_w != 5'd0);
        trace_push  = 1'b0;
        if (state_q == ST_RUN) begin
            cycle_d     = sat_inc(cycle_q, 1'b1);
            retire_d    = sat_inc(retire_q, retire_ev);
            stall_d_cnt = sat_inc(stall_q, stall_f || stall_d);
            flush_d     = sat_inc(flush_q, flush_e);
            stall_run_d = stall_f ? stall_run_q + SC_W'(1) : '0;
            trace_push  = retire_ev;
            if (pc == END_PC) begin
                state_d = ST_PASS;
                done_d  = 1'b1;
                pass_d  = 1'b1;
            end else if (cycle_q == CNT_W'(TIMEOUT - 1)) begin
                state_d     = ST_FAIL;
                done_d      = 1'b1;
                fail_code_d = FAIL_TIMEOUT;
            end else if (stall_f && (stall_run_q == SC_W'(STALL_LIMIT - 1))) begin
                state_d     = ST_FAIL;
                done_d      = 1'b1;
                fail_code_d = FAIL_HANG;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_code_q <= FAIL_NONE;
            cycle_q     <= '0;
            retire_q    <= '0;
            stall_q     <= '0;
            flush_q     <= '0;
            stall_run_q <= '0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_code_q <= fail_code_d;
            cycle_q     <= cycle_d;
            retire_q    <= retire_d;
            stall_q     <= stall_d_cnt;
            flush_q     <= flush_d;
            stall_run_q <= stall_run_d;
        end
    end

    assign done         = done_q;
    assign pass         = pass_q;
    assign fail_code    = fail_code_q;
    assign cycle_count  = cycle_q;
    assign retire_count = retire_q;
    assign stall_count  = stall_q;
    assign flush_count  = flush_q;

`ifdef PIPE_MON_TRACE_EN
    logic [4+CNT_W:0] trace_head;

    trace_fifo #(
        .DEPTH (TRACE_DEPTH),
        .WIDTH (5 + CNT_W)
    ) u_trace_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (trace_push),
        .push_data ({write_reg_w, cycle_q}),
        .pop       (trace_pop),
        .valid     (trace_valid),
        .head      (trace_head),
        .overflow  (trace_overflow)
    );

    assign trace_reg   = trace_head[CNT_W +: 5];
    assign trace_cycle = trace_head[CNT_W-1:0];
`else
    localparam int unused_trace_depth = TRACE_DEPTH;
    logic unused_trace;
    assign unused_trace   = trace_pop ^ trace_push;
    assign trace_valid    = 1'b0;
    assign trace_reg      = 5'd0;
    assign trace_cycle    = '0;
    assign trace_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_monitor.sv
// Directed bench for pipe_monitor; trace checks follow PIPE_MON_TRACE_EN.
module tb_pipe_monitor;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        reg_write_w;
    logic [4:0]  write_reg_w;
    logic        stall_f;
    logic        stall_d;
    logic        flush_e;
    logic        trace_pop;
    logic        trace_valid;
    logic [4:0]  trace_reg;
    logic [31:0] trace_cycle;
    logic        trace_overflow;
    logic        done;
    logic        pass;
    logic [1:0]  fail_code;
    logic [31:0] cycle_count;
    logic [31:0] retire_count;
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    int total = 0;
    int bad   = 0;

    pipe_monitor #(
        .END_PC      (32'h58),
        .TIMEOUT     (64),
        .STALL_LIMIT (16),
        .CNT_W       (32),
        .TRACE_DEPTH (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pc             (pc),
        .reg_write_w    (reg_write_w),
        .write_reg_w    (write_reg_w),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .flush_e        (flush_e),
        .trace_pop      (trace_pop),
        .trace_valid    (trace_valid),
        .trace_reg      (trace_reg),
        .trace_cycle    (trace_cycle),
        .trace_overflow (trace_overflow),
        .done           (done),
        .pass           (pass),
        .fail_code      (fail_code),
        .cycle_count    (cycle_count),
        .retire_count   (retire_count),
        .stall_count    (stall_count),
        .flush_count    (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_tv(input string tag, input logic exp);
`ifdef PIPE_MON_TRACE_EN
        chk(tag, {63'd0, trace_valid}, {63'd0, exp});
`else
        chk(tag, {63'd0, trace_valid}, 64'd0);
`endif
    endtask

    task automatic chk_ovf(input string tag, input logic exp);
`ifdef PIPE_MON_TRACE_EN
        chk(tag, {63'd0, trace_overflow}, {63'd0, exp});
`else
        chk(tag, {63'd0, trace_overflow}, 64'd0);
`endif
    endtask

    task automatic chk_head(input string tag, input int r, input int c);
`ifdef PIPE_MON_TRACE_EN
        chk({tag, "_reg"}, {59'd0, trace_reg}, 64'(r));
        chk({tag, "_cyc"}, {32'd0, trace_cycle}, 64'(c));
`else
        chk({tag, "_reg"}, {59'd0, trace_reg}, 64'd0);
        chk({tag, "_cyc"}, {32'd0, trace_cycle}, 64'd0);
`endif
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_pass"}, {63'd0, pass}, 64'd0);
        chk({tag, "_fail"}, {62'd0, fail_code}, 64'd0);
        chk({tag, "_cyc"}, {32'd0, cycle_count}, 64'd0);
        chk({tag, "_ret"}, {32'd0, retire_count}, 64'd0);
        chk({tag, "_stl"}, {32'd0, stall_count}, 64'd0);
        chk({tag, "_fls"}, {32'd0, flush_count}, 64'd0);
        chk({tag, "_tv"}, {63'd0, trace_valid}, 64'd0);
        chk({tag, "_tovf"}, {63'd0, trace_overflow}, 64'd0);
        chk({tag, "_treg"}, {59'd0, trace_reg}, 64'd0);
        chk({tag, "_tcyc"}, {32'd0, trace_cycle}, 64'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pc          = 32'h100;
        reg_write_w = 1'b0;
        write_reg_w = 5'd0;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        flush_e     = 1'b0;
        trace_pop   = 1'b0;
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, releases after one edge.
    task automatic do_reset(input string tag);
        idle_inputs();
        reset = 1'b1;
        #2;
        chk_all_zero(tag);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        #1;

        // Pass run: pc walks 0,4,8..., hitting END_PC on cycle 22.
        do_reset("rstA");
        for (int c = 0; c <= 22; c++) begin
            pc          = 32'(c * 4);
            flush_e     = (c == 3) || (c == 4);
            stall_d     = (c == 5);
            reg_write_w = (c == 6) || (c == 7);
            write_reg_w = (c == 7) ? 5'd5 : 5'd0;
            step();
            if (c == 21) chk("A_done_pre", {63'd0, done}, 64'd0);
        end
        chk("A_done", {63'd0, done}, 64'd1);
        chk("A_pass", {63'd0, pass}, 64'd1);
        chk("A_fail", {62'd0, fail_code}, 64'd0);
        chk("A_cyc", {32'd0, cycle_count}, 64'd23);
        chk("A_ret", {32'd0, retire_count}, 64'd1);
        chk("A_stl", {32'd0, stall_count}, 64'd1);
        chk("A_fls", {32'd0, flush_count}, 64'd2);
        chk_tv("A_tv", 1'b1);
        chk_head("A_head", 5, 7);
        pc          = 32'h5C;
        flush_e     = 1'b1;
        stall_f     = 1'b1;
        reg_write_w = 1'b1;
        write_reg_w = 5'd9;
        repeat (3) step();
        chk("A_cyc_frz", {32'd0, cycle_count}, 64'd23);
        chk("A_ret_frz", {32'd0, retire_count}, 64'd1);
        chk("A_stl_frz", {32'd0, stall_count}, 64'd1);
        chk("A_fls_frz", {32'd0, flush_count}, 64'd2);
        chk("A_done_stk", {63'd0, done}, 64'd1);
        chk_head("A_head_frz", 5, 7);
        reg_write_w = 1'b0;
        trace_pop   = 1'b1;
        step();
        trace_pop = 1'b0;
        chk_tv("A_tv_drained", 1'b0);

        // Timeout run: pc never matches.
        do_reset("rstB");
        repeat (63) step();
        chk("B_done_pre", {63'd0, done}, 64'd0);
        chk("B_cyc_pre", {32'd0, cycle_count}, 64'd63);
        step();
        chk("B_done", {63'd0, done}, 64'd1);
        chk("B_pass", {63'd0, pass}, 64'd0);
        chk("B_fail", {62'd0, fail_code}, 64'd1);
        chk("B_cyc", {32'd0, cycle_count}, 64'd64);
        repeat (3) step();
        chk("B_cyc_frz", {32'd0, cycle_count}, 64'd64);
        chk("B_fail_stk", {62'd0, fail_code}, 64'd1);

        // Hang: 16 consecutive fetch stalls from cycle 10.
        do_reset("rstC");
        repeat (10) step();
        stall_f = 1'b1;
        repeat (15) step();
        chk("C_done_15", {63'd0, done}, 64'd0);
        step();
        chk("C_done", {63'd0, done}, 64'd1);
        chk("C_pass", {63'd0, pass}, 64'd0);
        chk("C_fail", {62'd0, fail_code}, 64'd2);
        chk("C_stl", {32'd0, stall_count}, 64'd16);
        chk("C_cyc", {32'd0, cycle_count}, 64'd26);

        // 15 stalls then release, then another 15: never a hang.
        do_reset("rstC2");
        repeat (10) step();
        stall_f = 1'b1;
        repeat (15) step();
        stall_f = 1'b0;
        repeat (5) step();
        chk("C2_done", {63'd0, done}, 64'd0);
        chk("C2_fail", {62'd0, fail_code}, 64'd0);
        chk("C2_stl", {32'd0, stall_count}, 64'd15);
        chk("C2_cyc", {32'd0, cycle_count}, 64'd30);
        stall_f = 1'b1;
        repeat (15) step();
        stall_f = 1'b0;
        chk("C2_done_again", {63'd0, done}, 64'd0);
        chk("C2_stl_again", {32'd0, stall_count}, 64'd30);

        // 20 retires into a 16-deep trace, then drain.
        do_reset("rstD");
        reg_write_w = 1'b1;
        write_reg_w = 5'd1;
        chk_tv("D_tv_same_cycle", 1'b0);
        for (int i = 1; i <= 20; i++) begin
            write_reg_w = 5'(i);
            step();
            if (i == 1) begin
                chk_tv("D_tv_first", 1'b1);
                chk_head("D_head_first", 1, 0);
            end
        end
        reg_write_w = 1'b0;
        chk("D_ret", {32'd0, retire_count}, 64'd20);
        chk_ovf("D_ovf", 1'b1);
        trace_pop = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            chk_tv($sformatf("D_tv%0d", k), 1'b1);
            chk_head($sformatf("D_head%0d", k), k, k - 1);
            step();
        end
        trace_pop = 1'b0;
        chk_tv("D_tv_empty", 1'b0);

        // Full FIFO with simultaneous push and pop keeps 16 entries, no overflow.
        do_reset("rstE");
        reg_write_w = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            write_reg_w = 5'(i);
            step();
        end
        chk_ovf("E_ovf_full", 1'b0);
        chk_head("E_head_full", 1, 0);
        write_reg_w = 5'd17;
        trace_pop   = 1'b1;
        step();
        reg_write_w = 1'b0;
        chk_ovf("E_ovf_pp", 1'b0);
        for (int k = 2; k <= 17; k++) begin
            chk_tv($sformatf("E_tv%0d", k), 1'b1);
            chk_head($sformatf("E_head%0d", k), k, k - 1);
            step();
        end
        chk_tv("E_tv_empty", 1'b0);
        step();
        trace_pop = 1'b0;
        chk_tv("E_tv_pop_empty", 1'b0);
        chk_ovf("E_ovf_end", 1'b0);

        // Asynchronous reset mid-run with 5 entries queued.
        do_reset("rstF");
        reg_write_w = 1'b1;
        flush_e     = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            write_reg_w = 5'(i);
            step();
        end
        reg_write_w = 1'b0;
        flush_e     = 1'b0;
        chk_tv("F_tv_pre", 1'b1);
        chk("F_fls_pre", {32'd0, flush_count}, 64'd5);
        reset = 1'b1;
        #2;
        chk_all_zero("F_async");
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        chk("F_tv_after", {63'd0, trace_valid}, 64'd0);
        chk("F_cyc_after", {32'd0, cycle_count}, 64'd1);
        chk("F_ret_after", {32'd0, retire_count}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_monitor.md
# pipe_monitor

Synthesizable run monitor for the five-stage MIPS pipeline. It samples the fetch PC, writeback-stage register-write strobes and the hazard-unit stall/flush signals every cycle. It keeps saturating performance counters and decides pass/fail: pass on reaching a parametrised end PC, fail on a global timeout or a fetch-stall hang. Optionally it buffers a writeback trace in a FIFO for draining by the bench or a debug port. It sits beside `top`, driven only by observation taps.

## Interface
- `END_PC`, 32'h58, fetch PC that marks successful program end
- `TIMEOUT`, 4096, cycles in RUN before a timeout failure (≥2)
- `STALL_LIMIT`, 16, consecutive `stall_f` cycles that constitute a hang (≥2)
- `CNT_W`, 32, width of every counter and of `trace_cycle`
- `TRACE_DEPTH`, 16, trace FIFO entries (power of two, ≥2)

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `pc`  in  32  fetch-stage PC
- `reg_write_w`  in  1  writeback register-write enable
- `write_reg_w`  in  5  writeback destination register
- `stall_f`  in  1  fetch stall
- `stall_d`  in  1  decode stall
- `flush_e`  in  1  execute flush
- `trace_pop`  in  1  consume head trace entry
- `trace_valid`  out  1  FIFO non-empty
- `trace_reg`  out  5  head entry destination register
- `trace_cycle`  out  CNT_W  head entry cycle stamp
- `trace_overflow`  out  1  sticky: an entry was dropped
- `done`  out  1  terminal state reached
- `pass`  out  1  ended at `END_PC`
- `fail_code`  out  2  0 none, 1 timeout, 2 hang
- `cycle_count`, `retire_count`, `stall_count`, `flush_count`  out  CNT_W each

## Operation
- States: RUN, PASS, FAIL. Reset enters RUN. PASS and FAIL are sticky until `reset`.
- RUN, per edge, in priority order:
  - `pc == END_PC` → PASS
  - else `cycle_count == TIMEOUT-1` → FAIL, code 1
  - else `stall_f` is high and the consecutive-stall counter equals `STALL_LIMIT-1` → FAIL, code 2
- Consecutive-stall counter: increments while `stall_f`, clears to 0 on any cycle without `stall_f`.
- In RUN, counters increment once per cycle:
  - `cycle_count` unconditionally
  - `retire_count` on `reg_write_w && write_reg_w != 0`
  - `stall_count` on `stall_f || stall_d`
  - `flush_count` on `flush_e`
- All counters saturate at all-ones and freeze outside RUN.
- Trace push, in RUN only: on the same retire condition, push {`write_reg_w`, current `cycle_count`}.
- Trace full:
  - Push without pop → entry dropped, `trace_overflow` set.
  - Push with simultaneous pop → both occur, no overflow.
- Trace empty: a pop is ignored. Pops remain legal in PASS/FAIL so the FIFO can drain.
- Writes to register 0 are neither counted nor traced.

## Timing
- Reset values:
  - state RUN
  - every counter 0
  - `done`, `pass`, `fail_code`, `trace_valid`, `trace_overflow`, `trace_reg`, `trace_cycle` all 0
- All outputs are registered.
- `done`/`pass` rise on the edge that samples the matching `pc` and are visible the cycle after.
- `trace_valid` rises one cycle after the first push. A pushed entry is never visible in the same cycle.
- Head outputs are show-ahead. After a pop, the next entry appears the following cycle.
- `reset` asserted mid-run clears everything immediately, with no clock required.

## Configuration
- `PIPE_MON_TRACE_EN` defined: trace FIFO built as described.
- Undefined:
  - no FIFO storage
  - `trace_valid`, `trace_reg`, `trace_cycle`, `trace_overflow` tied 0
  - `trace_pop` ignored
  - counters and the pass/fail logic are unchanged

## Structure
- `pipe_mon_pkg`:
  - state enum (RUN/PASS/FAIL)
  - fail-code constants `FAIL_NONE`, `FAIL_TIMEOUT`, `FAIL_HANG`
  - trace entry struct {reg, cycle}
- One sub-module: `trace_fifo`, a synchronous FIFO with show-ahead head, parametrised by depth and entry width. It is instantiated only under `PIPE_MON_TRACE_EN`.

## Test plan
- `pc` steps 0,4,8…, reaches 0x58 at cycle 22 → `done`=1, `pass`=1, `fail_code`=0 next cycle; `cycle_count` frozen at 23 thereafter.
- `pc` never matches, `TIMEOUT`=64 → `done`=1, `pass`=0, `fail_code`=1, `cycle_count`=64.
- `stall_f` held 16 cycles from cycle 10, `STALL_LIMIT`=16 → `fail_code`=2 after 16th stall edge. Same run with 15 stalls then release → no fail.
- 20 retires to regs 1..20 with no pops, `TRACE_DEPTH`=16 → 16 entries retained, `trace_overflow`=1. Draining yields regs 1..16 with increasing stamps. A write to reg 0 leaves `retire_count` unchanged.
- FIFO full with push and pop on the same cycle → occupancy stays 16, `trace_overflow` stays 0.
- `reset` pulsed mid-run with 5 entries queued → all outputs 0 immediately; `trace_valid`=0 afterwards.
